// File: rtl/fake_signal_checker_if.sv
// ADC sample stream carrying packed {HG, LG} words and their qualifier.
interface fake_signal_checker_if;
  logic [23:0] ADC_IN;
  logic        ADC_VALID;

  modport master (output ADC_IN, output ADC_VALID);
  modport slave  (input  ADC_IN, input  ADC_VALID);
endinterface

// File: rtl/fake_signal_checker.sv
// Receive-side checker for injected fake ADC data: ramp lock/integrity
// checking and pulse count/interval/width measurement.
module fake_signal_checker #(
  parameter int unsigned PEDESTAL     = 200,
  parameter int unsigned LOCK_WORDS   = 4,
  parameter int unsigned MAX_MISS     = 8,
  parameter int unsigned PULSE_THRESH = 1024
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  CLEAR,
  input  logic                  CHECK_MODE,
  fake_signal_checker_if.slave  adc,
  output logic                  LOCKED,
  output logic                  ERR_STICKY,
  output logic [15:0]           ERR_COUNT,
  output logic [31:0]           WORD_COUNT,
  output logic [7:0]            RELOCK_COUNT,
  output logic [23:0]           FIRST_ERR_DATA,
  output logic [15:0]           PULSE_COUNT,
  output logic [31:0]           PULSE_INTERVAL,
  output logic [15:0]           PULSE_WIDTH
);

  localparam logic [11:0] PED    = 12'(PEDESTAL);
  localparam logic [11:0] THR    = 12'(PULSE_THRESH);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_WORDS);
  localparam logic [7:0]  MISS_N = 8'(MAX_MISS);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED, ST_PULSE} state_t;
  state_t state_q, state_d;

  logic        mode_q;
  logic [3:0]  match_q, match_n;
  logic [7:0]  miss_q, miss_n;
  logic [10:0] prev_r_q, expected_q;
  logic        first_edge_q, prev_above_q;
  logic [31:0] interval_q;
  logic [15:0] width_q;

  logic [11:0] hg, lg, r, exp_hg, exp_lg;
  logic        consistent, in_seq, word_ok, above;
  logic        mode_change, restart, sample_go;
  logic        acq_en, lock_en, pulse_en, lock_hit, relock_hit;

  // Decode the incoming word against the ramp rules and the pulse threshold
  always_comb begin
    hg         = adc.ADC_IN[23:12];
    lg         = adc.ADC_IN[11:0];
    r          = hg - PED;
    consistent = (hg >= PED) && !r[11] && (lg == (r >> 5) + PED);
    in_seq     = (r[10:0] == prev_r_q + 11'd1);
    exp_hg     = {1'b0, expected_q} + PED;
    exp_lg     = {6'b0, expected_q[10:5]} + PED;
    word_ok    = (hg == exp_hg) && (lg == exp_lg);
    above      = (hg >= THR);
  end

  // State register; mode is tracked every cycle to spot CHECK_MODE changes
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= CHECK_MODE;
    end
  end

  // FSM output decode: per-state processing enables and lock/relock events
  always_comb begin
    mode_change = (state_q != ST_IDLE) && (CHECK_MODE != mode_q);
    restart     = !CLEAR && ENABLE && ((state_q == ST_IDLE) || mode_change);
    sample_go   = !CLEAR && ENABLE && adc.ADC_VALID && !restart;
    acq_en      = sample_go && (state_q == ST_ACQUIRE);
    lock_en     = sample_go && (state_q == ST_LOCKED);
    pulse_en    = sample_go && (state_q == ST_PULSE);
    match_n     = (consistent && in_seq && (match_q != '0)) ? match_q + 4'd1
                                                           : {3'b000, consistent};
    miss_n      = word_ok ? '0 : miss_q + 8'd1;
    lock_hit    = acq_en && (match_n == LOCK_N);
    relock_hit  = lock_en && !word_ok && (miss_n == MISS_N);
  end

  // Next-state selection; CLEAR and ENABLE low both park the checker in IDLE
  always_comb begin
    state_d = state_q;
    if (CLEAR || !ENABLE)
      state_d = ST_IDLE;
    else if (restart)
      state_d = CHECK_MODE ? ST_PULSE : ST_ACQUIRE;
    else if (lock_hit)
      state_d = ST_LOCKED;
    else if (relock_hit)
      state_d = ST_ACQUIRE;
  end

  // Result counters and tracking registers, updated only by processed samples
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      LOCKED         <= 1'b0;
      ERR_STICKY     <= 1'b0;
      ERR_COUNT      <= '0;
      WORD_COUNT     <= '0;
      RELOCK_COUNT   <= '0;
      FIRST_ERR_DATA <= '0;
      PULSE_COUNT    <= '0;
      PULSE_INTERVAL <= '0;
      PULSE_WIDTH    <= '0;
      match_q        <= '0;
      miss_q         <= '0;
      prev_r_q       <= '0;
      expected_q     <= '0;
      first_edge_q   <= 1'b0;
      prev_above_q   <= 1'b0;
      interval_q     <= '0;
      width_q        <= '0;
    end else if (CLEAR) begin
      LOCKED         <= 1'b0;
      ERR_STICKY     <= 1'b0;
      ERR_COUNT      <= '0;
      WORD_COUNT     <= '0;
      RELOCK_COUNT   <= '0;
      FIRST_ERR_DATA <= '0;
      PULSE_COUNT    <= '0;
      PULSE_INTERVAL <= '0;
      PULSE_WIDTH    <= '0;
      match_q        <= '0;
      miss_q         <= '0;
      prev_r_q       <= '0;
      expected_q     <= '0;
      first_edge_q   <= 1'b0;
      prev_above_q   <= 1'b0;
      interval_q     <= '0;
      width_q        <= '0;
    end else begin
      LOCKED <= (state_d == ST_LOCKED);

      if (restart) begin
        match_q      <= '0;
        miss_q       <= '0;
        first_edge_q <= 1'b0;
      end

      if (acq_en) begin
        match_q  <= match_n;
        prev_r_q <= r[10:0];
        if (lock_hit)
          expected_q <= r[10:0] + 11'd1;
      end

      if (lock_en) begin
        WORD_COUNT <= (WORD_COUNT == '1) ? WORD_COUNT : WORD_COUNT + 32'd1;
        expected_q <= expected_q + 11'd1;
        if (!word_ok) begin
          ERR_COUNT  <= (ERR_COUNT == '1) ? ERR_COUNT : ERR_COUNT + 16'd1;
          ERR_STICKY <= 1'b1;
          if (!ERR_STICKY)
            FIRST_ERR_DATA <= adc.ADC_IN;
        end
        if (relock_hit) begin
          RELOCK_COUNT <= (RELOCK_COUNT == '1) ? RELOCK_COUNT : RELOCK_COUNT + 8'd1;
          match_q      <= '0;
          miss_q       <= '0;
        end else begin
          miss_q <= miss_n;
        end
      end

      if (pulse_en) begin
        prev_above_q <= above;
        if (above && !prev_above_q) begin
          PULSE_COUNT <= (PULSE_COUNT == '1) ? PULSE_COUNT : PULSE_COUNT + 16'd1;
          if (first_edge_q)
            PULSE_INTERVAL <= interval_q;
          interval_q   <= 32'd1;
          first_edge_q <= 1'b1;
        end else if (interval_q != '1) begin
          interval_q <= interval_q + 32'd1;
        end
        if (above) begin
          if (width_q != '1)
            width_q <= width_q + 16'd1;
        end else if (prev_above_q) begin
          PULSE_WIDTH <= width_q;
          width_q     <= '0;
        end
      end
    end
  end

endmodule

// File: doc/fake_signal_checker.md
Name: fake_signal_checker

Overview:
Receive-side companion to the fake signal injector. Monitors the packed 24-bit ADC word stream (HG in [23:12], LG in [11:0]) wherever fake data is routed, for example at the trigger/buffer input or on readback.
- Ramp mode: locks onto the ramp pattern and counts data-integrity errors.
- Pulse mode: measures rising-edge count, interval and width of the fake shower pulses.

Parameters:
PEDESTAL, 200, pedestal added by the injector to HG and LG
LOCK_WORDS, 4, consecutive consistent ramp words needed to lock (2..15)
MAX_MISS, 8, consecutive mismatches while locked that force relock (1..255)
PULSE_THRESH, 1024, HG threshold (raw ADC counts, pedestal included) for pulse detection

Ports:
CLK  in  1  system clock (120 MHz)
RESET_N  in  1  asynchronous active-low reset
ENABLE  in  1  checker run; low = IDLE, all counters hold
CLEAR  in  1  synchronous pulse; zeroes all counters and sticky/status outputs
CHECK_MODE  in  1  0 = ramp check, 1 = pulse measurement
ADC_IN  in  24  sample under test, {HG[11:0], LG[11:0]}
ADC_VALID  in  1  ADC_IN qualifier; only valid samples are processed or counted
LOCKED  out  1  ramp checker locked
ERR_STICKY  out  1  set on first ramp error since CLEAR/reset
ERR_COUNT  out  16  ramp mismatches while locked, saturating
WORD_COUNT  out  32  words checked while locked, saturating
RELOCK_COUNT  out  8  LOCKED->ACQUIRE transitions, saturating
FIRST_ERR_DATA  out  24  ADC_IN of the first error since CLEAR/reset
PULSE_COUNT  out  16  HG rising threshold crossings, saturating
PULSE_INTERVAL  out  32  valid samples between the last two rising edges
PULSE_WIDTH  out  16  valid samples above threshold in the last completed pulse

Behaviour:
- Reset: asynchronous on RESET_N low. Every output is 0; FSM goes to IDLE; internal match/miss/interval counters and the first-edge flag are cleared.
- CLEAR has the same effect synchronously. It takes priority over sample processing in the same cycle.
- All outputs are registered. Effects of a valid sample are visible on the clock edge after the one that samples it (1-cycle latency).
- Ramp word decode: R = HG - PEDESTAL (12-bit). The word is consistent iff HG >= PEDESTAL, R <= 2047 and LG == (R>>5) + PEDESTAL.
- FSM states: IDLE, ACQUIRE, LOCKED, PULSE.
  - IDLE: entered whenever ENABLE=0. Leaves to ACQUIRE (CHECK_MODE=0) or PULSE (CHECK_MODE=1) on the first cycle ENABLE=1.
  - Any CHECK_MODE change while enabled re-enters ACQUIRE/PULSE and clears the match count, miss count and first-edge flag. Result counters are not cleared.
  - ACQUIRE, on each valid sample:
    - Consistent and R == (prev_R+1) mod 2048 with match>0: match++.
    - Otherwise: match = 1 if consistent, else 0.
    - When match reaches LOCK_WORDS: go to LOCKED; expected = (R+1) mod 2048; LOCKED=1 from the next edge.
    - Samples processed in ACQUIRE are not counted as errors or words.
  - LOCKED, on each valid sample:
    - WORD_COUNT++ on every sample.
    - The sample is compared against the full predicted word {expected+PEDESTAL, (expected>>5)+PEDESTAL}.
    - Match: miss = 0.
    - Mismatch: ERR_COUNT++, miss++, ERR_STICKY=1; FIRST_ERR_DATA is loaded only if ERR_STICKY was 0.
    - expected always advances mod 2048, so one corrupted word yields exactly one error.
    - Wrap 2047->0 is legal.
    - When miss reaches MAX_MISS: go to ACQUIRE, RELOCK_COUNT++, LOCKED=0, match=0.
  - PULSE (LOCKED=0):
    - above = HG >= PULSE_THRESH.
    - Rising edge (above && !prev_above): PULSE_COUNT++. If a previous edge has been seen, PULSE_INTERVAL = interval counter. Then interval counter = 1 and the first-edge flag is set.
    - Otherwise the interval counter increments on each valid sample, saturating at 2^32-1.
    - Width counter increments on valid samples while above. On the falling edge, PULSE_WIDTH = width counter and the width counter is cleared.
    - prev_above updates only on valid samples.
- Invalid samples (ADC_VALID=0) change no state and no counter.
- Saturating counters hold at their maximum and never wrap.

Test Plan:
- Ramp: injector model R=0..4095, ADC_VALID=1 every cycle -> LOCKED rises one edge after the 4th sample; ERR_COUNT=0, WORD_COUNT=4092, RELOCK_COUNT=0.
- Single corruption: HG bit0 flipped at R=1000 while locked -> ERR_COUNT=1, ERR_STICKY=1, FIRST_ERR_DATA = corrupted word, LOCKED stays 1, no relock.
- Ramp jump: skip from R=500 to R=600 while locked -> ERR_COUNT=8, RELOCK_COUNT=1, LOCKED low for exactly 4 valid samples after the 8th miss, then relocked with no further errors.
- Pulse mode: HG=2247 for 100 samples, HG=200 otherwise, period 1200, five pulses -> PULSE_COUNT=5, PULSE_WIDTH=100, PULSE_INTERVAL=1200.
- ADC_VALID toggled every other cycle during a ramp -> same results as the first scenario, counted in valid samples only.
- RESET_N pulsed low mid-lock, asynchronously between clock edges -> all outputs 0 immediately; after release, the checker relocks after 4 samples with ERR_COUNT=0.
